// File: rtl/icu_io_sequencer.sv
// ---------------------------------------------------------------------------
// icu_io_sequencer
//
// Fetch/execute sequencer for the 1-bit ICU. It owns the program counter and
// drives the ROM address and the logic unit (LU). Bits addressed by the I/O
// field are routed through an input mux to the LU. LU store requests land in
// an addressable output latch. The block also handles JMP targets, a bounded
// call/return stack and the FLG0 halt.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   i_resume           single-cycle pulse that leaves HALT
//   o_rom_addr         ROM address (combinational ROM, changes per state only)
//   i_rom_data         ROM word: [DATA_W-1:IO_W] opcode, [IO_W-1:0] I/O address
//   o_lu_instruction   opcode presented to the LU (NOPO outside EXEC)
//   o_lu_data_in       selected input bit for the LU
//   i_lu_data_out      LU store data
//   i_lu_write_mode    LU store request
//   i_lu_jmp/rtn/flg0/flgf   LU flags, valid in EXEC
//   i_in_pins          external input bits
//   o_out_pins         registered output latch
//   o_halted           high while in HALT
//   o_stack_err        sticky call-stack over/underflow flag
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | rom_addr=pc, latch opcode, I/O address and selected input bit
// EXEC   | LU acts on latched opcode; store, then halt/jump/return/advance
// JTGT   | rom_addr=pc+1 reads jump target; optional push of pc+2 (call)
// HALT   | NOPO to LU, outputs held, wait for i_resume
// ---------------------------------------------------------------------------
module icu_io_sequencer #(
   parameter int ADDR_W      = 7,
   parameter int IO_W        = 4,
   parameter int N_IN        = 8,
   parameter int N_OUT       = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_resume,
   output logic [ADDR_W-1:0]   o_rom_addr,
   input  logic [IO_W+3:0]     i_rom_data,
   output logic [3:0]          o_lu_instruction,
   output logic                o_lu_data_in,
   input  logic                i_lu_data_out,
   input  logic                i_lu_write_mode,
   input  logic                i_lu_jmp,
   input  logic                i_lu_rtn,
   input  logic                i_lu_flg0,
   input  logic                i_lu_flgf,
   input  logic [N_IN-1:0]     i_in_pins,
   output logic [N_OUT-1:0]    o_out_pins,
   output logic                o_halted,
   output logic                o_stack_err
);

   localparam int DATA_W = IO_W + 4;
   localparam int MUX_W  = 1 << IO_W;
   localparam int SP_W   = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int STK_N  = 1 << IDX_W;

   localparam logic [3:0] OP_NOPO = 4'h0;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_JTGT  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [ADDR_W-1:0]   w_rom_addr;
   logic [IO_W-1:0]     r_io_addr;
   logic [3:0]          r_instr;
   logic                r_data_in;
   logic                r_call;
   logic                r_stack_err;
   logic [N_OUT-1:0]    r_out_pins;

   logic [ADDR_W-1:0]   r_stack [STK_N];
   logic [SP_W-1:0]     r_sp;

   logic                w_load;
   logic                w_clear_instr;
   logic                w_push;
   logic                w_pop;
   logic                w_err_set;
   logic                w_wr_en;

   logic [3:0]          w_rom_op;
   logic [IO_W-1:0]     w_rom_io;
   logic [ADDR_W-1:0]   w_rom_target;
   logic [MUX_W-1:0]    w_mux_vec;
   logic                w_mux_bit;

   logic [SP_W-1:0]     w_sp_m1;
   logic [IDX_W-1:0]    w_push_idx;
   logic [IDX_W-1:0]    w_pop_idx;
   logic [ADDR_W-1:0]   w_stack_top;
   logic                w_stack_empty;
   logic                w_stack_full;

   // ROM word fields
   assign w_rom_op     = i_rom_data[DATA_W-1:IO_W];
   assign w_rom_io     = i_rom_data[IO_W-1:0];
   assign w_rom_target = i_rom_data[ADDR_W-1:0];

   // Input mux: {out_pins, in_pins} zero-padded to the full I/O address space,
   // so addresses past N_IN+N_OUT read 0 without a separate range check.
   assign w_mux_vec = MUX_W'({r_out_pins, i_in_pins});
   assign w_mux_bit = w_mux_vec[w_rom_io];

   // Stack pointer counts entries; top of stack lives at r_sp-1.
   assign w_sp_m1       = r_sp - SP_W'(1);
   assign w_push_idx    = r_sp[IDX_W-1:0];
   assign w_pop_idx     = w_sp_m1[IDX_W-1:0];
   assign w_stack_top   = r_stack[w_pop_idx];
   assign w_stack_empty = (r_sp == '0);
   assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_rom_addr    = r_pc;
      w_load        = 1'b0;
      w_clear_instr = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_err_set     = 1'b0;
      w_wr_en       = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_load      = 1'b1;
            w_state_nxt = S_EXEC;
         end

         S_EXEC: begin
            w_wr_en       = i_lu_write_mode;
            w_clear_instr = 1'b1;
            if (i_lu_flg0) begin
               w_pc_nxt    = r_pc + ADDR_W'(1);
               w_state_nxt = S_HALT;
            end else if (i_lu_jmp) begin
               w_state_nxt = S_JTGT;
            end else if (i_lu_rtn) begin
               if (w_stack_empty) begin
                  w_err_set = 1'b1;
                  w_pc_nxt  = '0;
               end else begin
                  w_pop    = 1'b1;
                  w_pc_nxt = w_stack_top;
               end
               w_state_nxt = S_FETCH;
            end else begin
               w_pc_nxt    = r_pc + ADDR_W'(1);
               w_state_nxt = S_FETCH;
            end
         end

         S_JTGT: begin
            // Target word sits right after the jump opcode.
            w_rom_addr = r_pc + ADDR_W'(1);
            w_pc_nxt   = w_rom_target;
            if (r_call) begin
               // A call into a full stack still jumps; only the return is lost.
               if (w_stack_full) begin
                  w_err_set = 1'b1;
               end else begin
                  w_push = 1'b1;
               end
            end
            w_state_nxt = S_FETCH;
         end

         S_HALT: begin
            if (i_resume) begin
               w_state_nxt = S_FETCH;
            end
         end

         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_io_addr   <= '0;
         r_instr     <= OP_NOPO;
         r_data_in   <= 1'b0;
         r_call      <= 1'b0;
         r_stack_err <= 1'b0;
         r_out_pins  <= '0;
         r_sp        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;

         // The opcode is shown to the LU only during EXEC; JTGT, HALT and
         // the following FETCH see NOPO.
         if (w_load) begin
            r_instr   <= w_rom_op;
            r_io_addr <= w_rom_io;
            r_data_in <= w_mux_bit;
         end else if (w_clear_instr) begin
            r_instr   <= OP_NOPO;
            r_data_in <= 1'b0;
         end

         // flgf qualifies the jump that follows in JTGT as a call.
         if (r_state == S_EXEC) begin
            r_call <= i_lu_flgf;
         end

         if (w_err_set) begin
            r_stack_err <= 1'b1;
         end

         if (w_push) begin
            r_sp <= r_sp + SP_W'(1);
         end else if (w_pop) begin
            r_sp <= w_sp_m1;
         end

         // Addresses at or above N_OUT match no latch bit, so they never store.
         for (int k = 0; k < N_OUT; k++) begin
            if (w_wr_en && (r_io_addr == IO_W'(k))) begin
               r_out_pins[k] <= i_lu_data_out;
            end
         end
      end
   end

   // Return addresses need no reset; the stack pointer alone marks validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_stack[w_push_idx] <= r_pc + ADDR_W'(2);
      end
   end

   assign o_rom_addr       = w_rom_addr;
   assign o_lu_instruction = r_instr;
   assign o_lu_data_in     = r_data_in;
   assign o_out_pins       = r_out_pins;
   assign o_halted         = (r_state == S_HALT);
   assign o_stack_err      = r_stack_err;

endmodule
